// File: rtl/adapter_pkg.sv
// Shared types for the CPRI<->DUC adapters: sample/pair layouts, output phase and unpacking.
package adapter_pkg;

    localparam int SAMPLE_W = 16;

    typedef struct packed {
        logic [SAMPLE_W-1:0] q;
        logic [SAMPLE_W-1:0] i;
    } sample_t;

    typedef struct packed {
        sample_t s1;
        sample_t s0;
    } pair_t;

    typedef enum logic {PH_LO, PH_HI} phase_e;

    // Low halves of the CPRI words form sample0, high halves sample1.
    function automatic pair_t unpack_pair(input logic [2*SAMPLE_W-1:0] iq_i,
                                          input logic [2*SAMPLE_W-1:0] iq_q);
        pair_t p;
        p.s0.i = iq_i[SAMPLE_W-1:0];
        p.s0.q = iq_q[SAMPLE_W-1:0];
        p.s1.i = iq_i[2*SAMPLE_W-1:SAMPLE_W];
        p.s1.q = iq_q[2*SAMPLE_W-1:SAMPLE_W];
        return p;
    endfunction

endpackage

// File: rtl/adapter_dl_fifo.sv
// Synchronous 64-bit sample-pair FIFO with combinational head read.
// A push while full is accepted only when a pop happens in the same cycle.
module adapter_dl_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [63:0]                   din,
    output logic [63:0]                   head,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full  = (level == (AW+1)'(FIFO_DEPTH));
    assign empty = (level == '0);
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/adapter_dl.sv
// Downlink CPRI-to-DUC adapter: buffers IQ pairs and streams them one sample per beat.
// Optional overflow status outputs are enabled with ADAPTER_DL_STATUS_EN.
module adapter_dl #(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [2*SAMPLE_W-1:0]         iq_rx_i,
    input  logic [2*SAMPLE_W-1:0]         iq_rx_q,
    input  logic                          iq_rx_valid,
    output logic [2*SAMPLE_W-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef ADAPTER_DL_STATUS_EN
    ,
    output logic                          ovf_sticky,
    output logic [15:0]                   ovf_count
`endif
);

    import adapter_pkg::*;

    pair_t                       in_pair;
    pair_t                       head_pair;
    logic [63:0]                 head_w;
    logic                        full;
    logic                        empty;
    logic                        hs;
    logic                        pop;
    phase_e                      phase;
    logic [2*SAMPLE_W-1:0]       last_q;

    assign in_pair   = unpack_pair(iq_rx_i, iq_rx_q);
    assign head_pair = pair_t'(head_w);

    adapter_dl_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (iq_rx_valid),
        .pop   (pop),
        .din   (in_pair),
        .head  (head_w),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    assign m_axis_tvalid = ~empty;
    assign hs            = m_axis_tvalid & m_axis_tready;
    assign pop           = hs & (phase == PH_HI);

    // Head and phase only move on a handshake, so tdata is stable under back-pressure;
    // when drained, the last emitted sample is held.
    assign m_axis_tdata = empty           ? last_q :
                          (phase == PH_HI) ? head_pair.s1 : head_pair.s0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase  <= PH_LO;
            last_q <= '0;
        end else if (hs) begin
            last_q <= m_axis_tdata;
            case (phase)
                PH_LO:   phase <= PH_HI;
                default: phase <= PH_LO;
            endcase
        end
    end

`ifdef ADAPTER_DL_STATUS_EN
    logic drop;

    assign drop = iq_rx_valid & full & ~pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end else if (drop) begin
            ovf_sticky <= 1'b1;
            if (ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adapter_dl.sv
// Self-checking bench for adapter_dl against a sample-queue reference model.
module tb_adapter_dl;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] iq_rx_i = '0;
    logic [31:0] iq_rx_q = '0;
    logic        iq_rx_valid = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [3:0]  fifo_level;
`ifdef ADAPTER_DL_STATUS_EN
    logic        ovf_sticky;
    logic [15:0] ovf_count;
`endif

    adapter_dl #(.SAMPLE_W(16), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .iq_rx_i       (iq_rx_i),
        .iq_rx_q       (iq_rx_q),
        .iq_rx_valid   (iq_rx_valid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .fifo_level    (fifo_level)
`ifdef ADAPTER_DL_STATUS_EN
        ,
        .ovf_sticky    (ovf_sticky),
        .ovf_count     (ovf_count)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = '0;
    int          drops = 0;

    // Stored pairs = samples still owed, rounded up (a half-sent pair still counts).
    function automatic int pairs();
        return (exp_q.size() + 1) / 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one clock of stimulus, check outputs against the model, then advance the model.
    task automatic cycle(input logic v, input logic [31:0] di, input logic [31:0] dq, input logic rdy);
        int   lvl;
        logic hs;
        logic popping;
        iq_rx_valid   = v;
        iq_rx_i       = di;
        iq_rx_q       = dq;
        m_axis_tready = rdy;
        #1;
        lvl = pairs();
        check("tvalid", 32'(m_axis_tvalid), 32'(lvl != 0));
        check("tdata", m_axis_tdata, (lvl != 0) ? exp_q[0] : last_exp);
        check("level", 32'(fifo_level), 32'(lvl));
`ifdef ADAPTER_DL_STATUS_EN
        check("ovf_sticky", 32'(ovf_sticky), 32'(drops != 0));
        check("ovf_count", 32'(ovf_count), (drops > 65535) ? 32'd65535 : 32'(drops));
`endif
        hs      = (lvl != 0) && rdy;
        popping = hs && (exp_q.size() % 2 == 1);
        if (hs) last_exp = exp_q.pop_front();
        if (v) begin
            if (lvl == DEPTH && !popping) begin
                drops++;
            end else begin
                exp_q.push_back({dq[15:0], di[15:0]});
                exp_q.push_back({dq[31:16], di[31:16]});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        iq_rx_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        last_exp = '0;
        drops    = 0;
        #1;
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_tdata", m_axis_tdata, 32'd0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, rdy);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // 1: single pair, tready high
        cycle(1'b1, 32'h2222_1111, 32'h4444_3333, 1'b1);
        check("t1_beat0", m_axis_tdata, 32'h3333_1111);
        check("t1_valid0", 32'(m_axis_tvalid), 32'd1);
        cycle(1'b0, '0, '0, 1'b1);
        check("t1_beat1", m_axis_tdata, 32'h4444_2222);
        cycle(1'b0, '0, '0, 1'b1);
        check("t1_after", 32'(m_axis_tvalid), 32'd0);
        idle(2, 1'b1);

        // 2: back-pressure with 3 pairs
        for (int k = 0; k < 3; k++) cycle(1'b1, $urandom, $urandom, 1'b0);
        idle(10, 1'b0);
        check("t2_level", 32'(fifo_level), 32'd3);
        idle(8, 1'b1);
        check("t2_drained", 32'(fifo_level), 32'd0);

        // 3: overflow, 10 strobes into depth 8
        do_reset();
        for (int k = 1; k <= 10; k++) cycle(1'b1, 32'h1000_0000 + k, 32'h2000_0000 + k, 1'b0);
        check("t3_level", 32'(fifo_level), 32'd8);
`ifdef ADAPTER_DL_STATUS_EN
        check("t3_sticky", 32'(ovf_sticky), 32'd1);
        check("t3_count", 32'(ovf_count), 32'd2);
`endif
        idle(20, 1'b1);

        // 4: full FIFO, push coinciding with HI-phase pop
        do_reset();
        for (int k = 0; k < 8; k++) cycle(1'b1, $urandom, $urandom, 1'b0);
        cycle(1'b0, '0, '0, 1'b1);
        cycle(1'b1, 32'hAAAA_5555, 32'hCCCC_3333, 1'b1);
        check("t4_level", 32'(fifo_level), 32'd8);
`ifdef ADAPTER_DL_STATUS_EN
        check("t4_count", 32'(ovf_count), 32'd0);
`endif
        idle(20, 1'b1);

        // 5: reset while a pair is half sent
        do_reset();
        for (int k = 0; k < 4; k++) cycle(1'b1, $urandom, $urandom, 1'b0);
        cycle(1'b0, '0, '0, 1'b1);
        do_reset();
        cycle(1'b1, 32'h0202_0101, 32'h0404_0303, 1'b0);
        check("t5_first", m_axis_tdata, 32'h0303_0101);
        idle(4, 1'b1);

        // 6: random tready (stalled 30%) against one strobe per 4 clocks
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            for (int c = 0; c < 4; c++) begin
                cycle(c == 0, $urandom, $urandom, $urandom_range(0, 99) >= 30);
            end
        end
        idle(40, 1'b1);
        check("t6_level", 32'(fifo_level), 32'd0);
`ifdef ADAPTER_DL_STATUS_EN
        check("t6_drops", 32'(ovf_count), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
